rv_decode_stage: RTL and testbench

//  Registered, XLEN-parametrised RISC-V base-integer decode stage between fetch and issue.

---
 rtl/rv_decode_if.sv | 37 +++
 rtl/rv_decode_stage.sv | 179 +++++++++++++++++
 tb/tb_rv_decode_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_if.sv
// rv_decode_if: fetch-side and issue-side valid/ready bundle for rv_decode_stage.
// The master modport belongs to the environment (fetch + issue).
// The slave modport belongs to the decode stage.
interface rv_decode_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [11:0]     out_funct12;
    logic [XLEN-1:0] out_imm;
    logic            out_decode_error;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_opcode, out_rd, out_rs1,
               out_rs2, out_funct3, out_funct7, out_funct12, out_imm, out_decode_error
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_opcode, out_rd, out_rs1,
               out_rs2, out_funct3, out_funct7, out_funct12, out_imm, out_decode_error
    );
endinterface

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RISC-V base-integer decode stage with a 2-entry skid buffer.
// The instruction is decoded combinationally on entry; immediate and error flag are stored
// with the entry, and the buffer head drives every out_* signal.
// Optional feature macro: RV_DECODE_M_EN (when defined, M-extension encodings are legal).
module rv_decode_stage #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    rv_decode_if.slave  bus
);

`ifdef RV_DECODE_M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic            err;
    } entry_t;

    // Format-selected immediate; each raw field is held signed so the cast sign-extends.
    function automatic logic [XLEN-1:0] calc_imm(input logic [31:0] i);
        logic signed [11:0] imm_i;
        logic signed [11:0] imm_s;
        logic signed [12:0] imm_b;
        logic signed [31:0] imm_u;
        logic signed [20:0] imm_j;
        logic [XLEN-1:0]    imm;
        imm_i = i[31:20];
        imm_s = {i[31:25], i[11:7]};
        imm_b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        imm_u = {i[31:12], 12'b0};
        imm_j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        imm   = '0;
        case (i[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM: imm = XLEN'(imm_i);
            OPC_STORE:                                                imm = XLEN'(imm_s);
            OPC_BRANCH:                                               imm = XLEN'(imm_b);
            OPC_LUI, OPC_AUIPC:                                       imm = XLEN'(imm_u);
            OPC_JAL:                                                  imm = XLEN'(imm_j);
            default:                                                  imm = '0;
        endcase
        return imm;
    endfunction

    // Illegal-encoding detection; errored instructions still flow downstream for trapping.
    function automatic logic calc_err(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       err;
        f3  = i[14:12];
        f7  = i[31:25];
        err = 1'b0;
        case (i[6:0])
            OPC_LOAD:     err = (f3 == 3'd7) || ((XLEN == 32) && (f3 == 3'd3 || f3 == 3'd6));
            OPC_STORE:    err = (XLEN == 32) ? (f3 >= 3'd3) : (f3 >= 3'd4);
            OPC_BRANCH:   err = (f3 == 3'd2) || (f3 == 3'd3);
            OPC_JALR:     err = (f3 != 3'd0);
            OPC_OP: begin
                if (f7 == 7'h00)      err = 1'b0;
                else if (f7 == 7'h20) err = !(f3 == 3'd0 || f3 == 3'd5);
                else if (f7 == 7'h01) err = !M_EN;
                else                  err = 1'b1;
            end
            OPC_OP32: begin
                if (XLEN == 32)       err = 1'b1;
                else if (f7 == 7'h00) err = 1'b0;
                else if (f7 == 7'h20) err = !(f3 == 3'd0 || f3 == 3'd5);
                else if (f7 == 7'h01) err = !M_EN || (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3);
                else                  err = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == 3'd1)
                    err = (XLEN == 32) ? (i[31:25] != 7'h00) : (i[31:26] != 6'h00);
                else if (f3 == 3'd5)
                    err = (XLEN == 32) ? !(i[31:25] == 7'h00 || i[31:25] == 7'h20)
                                       : !(i[31:26] == 6'h00 || i[31:26] == 6'h10);
                else
                    err = 1'b0;
            end
            OPC_OP_IMM32:                                      err = (XLEN == 32);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_MISC_MEM: err = 1'b0;
            default:                                           err = 1'b1;
        endcase
        if (i[1:0] != 2'b11) err = 1'b1;
        return err;
    endfunction

    entry_t     new_p0;
    entry_t     slot0_p1;
    entry_t     slot1_p1;
    logic [1:0] occ_p1;
    logic [1:0] occ_next;
    logic       in_ready_p1;
    logic       push;
    logic       pop;

    // Decode the offered instruction into the entry format stored by the buffer.
    always_comb begin
        new_p0      = '0;
        new_p0.inst = bus.in_inst;
        new_p0.pc   = bus.in_pc;
        new_p0.imm  = calc_imm(bus.in_inst);
        new_p0.err  = calc_err(bus.in_inst);
    end

    // Transfer detection and next occupancy; flush empties the buffer regardless of transfers.
    always_comb begin
        push     = bus.in_valid && in_ready_p1;
        pop      = (occ_p1 != 2'd0) && bus.out_ready;
        occ_next = occ_p1;
        if (bus.flush)
            occ_next = 2'd0;
        else if (push && !pop)
            occ_next = occ_p1 + 2'd1;
        else if (pop && !push)
            occ_next = occ_p1 - 2'd1;
    end

    // --- stage p1: skid buffer, head in slot0, in_ready registered from next occupancy ---
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_p1      <= 2'd0;
            in_ready_p1 <= 1'b1;
            slot0_p1    <= '0;
            slot1_p1    <= '0;
        end else begin
            occ_p1      <= occ_next;
            in_ready_p1 <= (occ_next != 2'd2);
            if (!bus.flush) begin
                if (pop) begin
                    // push with pop only happens at occupancy 1, so the new entry becomes head
                    if (push) slot0_p1 <= new_p0;
                    else      slot0_p1 <= slot1_p1;
                end else if (push) begin
                    if (occ_p1 == 2'd0) slot0_p1 <= new_p0;
                    else                slot1_p1 <= new_p0;
                end
            end
        end
    end

    // Head entry drives the issue side; register fields are slices of the stored instruction.
    always_comb begin
        bus.in_ready         = in_ready_p1;
        bus.out_valid        = (occ_p1 != 2'd0);
        bus.out_inst         = slot0_p1.inst;
        bus.out_pc           = slot0_p1.pc;
        bus.out_opcode       = slot0_p1.inst[6:0];
        bus.out_rd           = slot0_p1.inst[11:7];
        bus.out_rs1          = slot0_p1.inst[19:15];
        bus.out_rs2          = slot0_p1.inst[24:20];
        bus.out_funct3       = slot0_p1.inst[14:12];
        bus.out_funct7       = slot0_p1.inst[31:25];
        bus.out_funct12      = slot0_p1.inst[31:20];
        bus.out_imm          = slot0_p1.imm;
        bus.out_decode_error = slot0_p1.err;
    end

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed vectors for rv_decode_stage (XLEN=32) with hand-computed results.
module tb_rv_decode_stage;

    localparam int XLEN = 32;

`ifdef RV_DECODE_M_EN
    localparam logic MUL_ERR = 1'b0;
`else
    localparam logic MUL_ERR = 1'b1;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic        err;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[11];

    rv_decode_if #(.XLEN(XLEN)) bus ();

    rv_decode_stage #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1'b0,    5'd1,  5'd0,  5'd31, 3'd0}; // ADDI x1,x0,-1
        vecs[1]  = '{32'hFE208EE3, 32'hFFFFFFFC, 1'b0,    5'd29, 5'd1,  5'd2,  3'd0}; // BEQ x1,x2,-4
        vecs[2]  = '{32'h022081B3, 32'h00000000, MUL_ERR, 5'd3,  5'd1,  5'd2,  3'd0}; // MUL x3,x1,x2
        vecs[3]  = '{32'h00000000, 32'h00000000, 1'b1,    5'd0,  5'd0,  5'd0,  3'd0}; // all zero
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1,    5'd31, 5'd31, 5'd31, 3'd7}; // all ones
        vecs[5]  = '{32'h0020A423, 32'h00000008, 1'b0,    5'd8,  5'd1,  5'd2,  3'd2}; // SW x2,8(x1)
        vecs[6]  = '{32'h123452B7, 32'h12345000, 1'b0,    5'd5,  5'd8,  5'd3,  3'd5}; // LUI x5,0x12345
        vecs[7]  = '{32'hFF9FF0EF, 32'hFFFFFFF8, 1'b0,    5'd1,  5'd31, 5'd25, 3'd7}; // JAL x1,-8
        vecs[8]  = '{32'h00002063, 32'h00000000, 1'b1,    5'd0,  5'd0,  5'd0,  3'd2}; // BRANCH funct3=2
        vecs[9]  = '{32'h4030D093, 32'h00000403, 1'b0,    5'd1,  5'd1,  5'd3,  3'd5}; // SRAI x1,x1,3
        vecs[10] = '{32'h2030D093, 32'h00000203, 1'b1,    5'd1,  5'd1,  5'd3,  3'd5}; // SRLI bad funct7

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_inst", 64'(bus.out_inst), 64'd0);
        check("rst_out_imm", 64'(bus.out_imm), 64'd0);
        check("rst_out_pc", 64'(bus.out_pc), 64'd0);
        rst = 1'b0;
        step();

        // Streaming at one per cycle: each vector appears exactly one cycle after acceptance.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = vecs[i].inst;
            bus.in_pc    = 32'h1000 + 32'(i * 4);
            step();
            check("stream_valid", 64'(bus.out_valid), 64'd1);
            check("stream_ready", 64'(bus.in_ready), 64'd1);
            check("stream_inst", 64'(bus.out_inst), 64'(vecs[i].inst));
            check("stream_pc", 64'(bus.out_pc), 64'h1000 + 64'(i * 4));
            check("stream_imm", 64'(bus.out_imm), 64'(vecs[i].imm));
            check("stream_err", 64'(bus.out_decode_error), 64'(vecs[i].err));
            check("stream_rd", 64'(bus.out_rd), 64'(vecs[i].rd));
            check("stream_rs1", 64'(bus.out_rs1), 64'(vecs[i].rs1));
            check("stream_rs2", 64'(bus.out_rs2), 64'(vecs[i].rs2));
            check("stream_f3", 64'(bus.out_funct3), 64'(vecs[i].f3));
            if (i == 0) begin
                check("addi_opcode", 64'(bus.out_opcode), 64'h13);
                check("addi_funct7", 64'(bus.out_funct7), 64'h7F);
                check("addi_funct12", 64'(bus.out_funct12), 64'hFFF);
            end
            if (i == 2) check("mul_funct7", 64'(bus.out_funct7), 64'h01);
        end
        bus.in_valid = 1'b0;
        step();
        check("drained_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure: A and B fill the buffer, C waits until the buffer drains.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h00100093;   // A: ADDI x1,x0,1
        step();
        check("bp1_valid", 64'(bus.out_valid), 64'd1);
        check("bp1_ready", 64'(bus.in_ready), 64'd1);
        check("bp1_inst", 64'(bus.out_inst), 64'h00100093);
        bus.in_inst = 32'h00200113;     // B: ADDI x2,x0,2
        step();
        check("bp2_ready", 64'(bus.in_ready), 64'd0);
        check("bp2_inst", 64'(bus.out_inst), 64'h00100093);
        bus.in_inst = 32'h00300193;     // C: ADDI x3,x0,3
        step();
        check("bp3_ready", 64'(bus.in_ready), 64'd0);
        check("bp3_inst", 64'(bus.out_inst), 64'h00100093);
        check("bp3_imm", 64'(bus.out_imm), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp4_inst", 64'(bus.out_inst), 64'h00200113);
        check("bp4_imm", 64'(bus.out_imm), 64'd2);
        check("bp4_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("bp5_inst", 64'(bus.out_inst), 64'h00300193);
        check("bp5_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        step();
        check("bp6_valid", 64'(bus.out_valid), 64'd0);

        // Flush with two entries held and a third offered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h00400213;   // D
        step();
        bus.in_inst = 32'h00500293;     // E
        step();
        check("fl_full_ready", 64'(bus.in_ready), 64'd0);
        bus.in_inst = 32'h00600313;     // F, offered during flush
        bus.flush   = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        check("fl_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("fl_after_valid", 64'(bus.out_valid), 64'd0);

        // Flush beats a same-cycle accepted instruction.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h00700393;
        step();
        bus.in_inst = 32'h00800413;
        bus.flush   = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_acc_valid", 64'(bus.out_valid), 64'd0);
        check("fl_acc_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("fl_acc_after", 64'(bus.out_valid), 64'd0);

        // Reset mid-stall with two entries held and a third offered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h00900493;
        step();
        bus.in_inst = 32'h00A00513;
        step();
        bus.in_inst = 32'h00B00593;
        rst         = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rs_valid", 64'(bus.out_valid), 64'd0);
        check("rs_ready", 64'(bus.in_ready), 64'd1);
        check("rs_inst", 64'(bus.out_inst), 64'd0);
        bus.out_ready = 1'b1;
        step();
        check("rs_after_valid", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
